muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit owning the HI/LO register pair of the MIPS core.
//  Executes MULTU, MULT, DIVU and DIV over several cycles and accepts MTHI/MTLO writes.
//  Presents HI/LO to the result mux for MFHI/MFLO.
//  Sits beside the ALU; the decoder issues start/op, and the datapath stalls MFHI/MFLO/MT* while busy=1.
// PARAMETERS
//  WIDTH           32  operand width; HI and LO are each WIDTH bits
//  BITS_PER_CYCLE  1   bits retired per iteration; legal values 1, 2 or 4; WIDTH % BITS_PER_CYCLE == 0
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  start        in   1      launch operation; sampled only when busy=0
//  op           in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a            in   WIDTH  rs operand (multiplicand / dividend)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  hi_we        in   1      MTHI write strobe
//  lo_we        in   1      MTLO write strobe
//  wdata        in   WIDTH  MTHI/MTLO data
//  busy         out  1      operation in flight; datapath stalls HI/LO access
//  done         out  1      one-cycle pulse; HI/LO updated on the same edge
//  div_by_zero  out  1      sticky until next start; set by DIV/DIVU with b==0
//  hi           out  WIDTH  HI register (product high / remainder)
//  lo           out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset (reset=0, any time, async): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
//   Any in-flight operation is discarded.
//  Latency: N = WIDTH/BITS_PER_CYCLE.
//   start sampled at edge E0; busy=1 after E0.
//   CALC spans edges E1..EN; FIX at E(N+1) writes hi/lo and sets done=1, busy=0.
//   Total latency: N+1 cycles (33 for the defaults).
//  FSM:
//   IDLE -start-> CALC (or FIX directly on divide with b==0)
//   CALC -N iterations-> FIX
//   FIX -> IDLE with done pulse
//  start while busy=1: ignored (not queued). op, a and b are captured at E0 only.
//  Signed ops: operate on magnitudes (|x| in WIDTH+1 bits, so -2^(WIDTH-1) is legal).
//   Sign correction happens in FIX.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product; shift-add, BITS_PER_CYCLE multiplier bits per cycle.
//  DIVU/DIV: restoring division; lo=quotient, hi=remainder.
//   Quotient truncates toward zero. Remainder takes the sign of the dividend.
//   DIV of -2^(WIDTH-1) by -1: lo=0x80000000, hi=0 (wraps, no flag).
//  Divide by zero: skip CALC; done at E1. hi=a, lo=all ones, div_by_zero=1.
//  hi_we/lo_we: write hi/lo at the edge only when busy=0 and no start is accepted that cycle.
//   Otherwise the write is dropped; start wins a collision.
//   hi_we and lo_we together write both registers with wdata.
//  hi/lo hold their values during CALC; they change only at FIX, on an MT* write, or on reset.
//  done is never asserted except for exactly one cycle after FIX.
// TESTING
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
//  MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU a=0x1234 b=0 -> done one cycle after start; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1.
//   Next start clears div_by_zero.
//  DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
//  Start MULTU, pulse start with new operands at cycle 10 and hi_we at cycle 12 ->
//   first result only; no second done; hi unaffected by the dropped write.
//  Assert reset at cycle 15 of a DIV -> busy=0, hi=lo=0 immediately; after release a fresh MULTU 7*6 gives lo=42.
//  Repeat all cases with BITS_PER_CYCLE=2 and 4 -> identical results at latencies 17 and 9.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative multiply/divide unit owning the MIPS HI/LO pair.
//             MULTU/MULT by shift-add, DIVU/DIV by restoring division,
//             BITS_PER_CYCLE result bits retired per CALC cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_N  = WIDTH / BITS_PER_CYCLE;
    localparam int c_CW = $clog2(c_N + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_op_div;
    logic             r_neg_q;     // negate product / quotient in FIX
    logic             r_neg_r;     // negate remainder in FIX
    logic [WIDTH-1:0] r_m;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_wh;        // partial product high / partial remainder
    logic [WIDTH-1:0] r_wl;        // multiplier shifting out / quotient shifting in
    logic [c_CW-1:0]  r_cnt;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic [WIDTH-1:0] w_sh;
    logic [WIDTH-1:0] w_sl;
    logic [WIDTH:0]   w_sum;
    logic             w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_accept = start && (r_state == c_IDLE);
    assign w_a_neg  = op[0] && a[WIDTH-1];
    assign w_b_neg  = op[0] && b[WIDTH-1];
    // Magnitudes fit in WIDTH unsigned bits, so the most negative value is legal
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_div0   = op[1] && (b == '0);

    assign busy        = (r_state != c_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

    // One CALC iteration: BITS_PER_CYCLE single-bit shift-add or restoring-divide steps
    always_comb begin
        w_sh   = r_wh;
        w_sl   = r_wl;
        w_sum  = '0;
        w_qbit = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_op_div) begin
                w_sum  = {w_sh, w_sl[WIDTH-1]};
                w_qbit = (w_sum >= {1'b0, r_m});
                if (w_qbit) begin
                    w_sum = w_sum - {1'b0, r_m};
                end
                w_sh = w_sum[WIDTH-1:0];
                w_sl = {w_sl[WIDTH-2:0], w_qbit};
            end else begin
                w_sum = {1'b0, w_sh} + (w_sl[0] ? {1'b0, r_m} : '0);
                w_sh  = w_sum[WIDTH:1];
                w_sl  = {w_sum[0], w_sl[WIDTH-1:1]};
            end
        end
    end

    // Sign correction of the unsigned magnitude result
    always_comb begin
        w_prod   = {r_wh, r_wl};
        w_fix_hi = r_wh;
        w_fix_lo = r_wl;
        if (r_op_div) begin
            w_fix_lo = r_neg_q ? -r_wl : r_wl;
            w_fix_hi = r_neg_r ? -r_wh : r_wh;
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Next-state logic; divide by zero bypasses CALC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div0 ? c_FIX : c_CALC;
                end
            end
            c_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_FIX;
                end
            end
            c_FIX:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration, result write-back and MTHI/MTLO writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_m      <= '0;
            r_wh     <= '0;
            r_wl     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == c_FIX);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op_div <= op[1];
                        r_cnt    <= c_CW'(c_N - 1);
                        r_dz     <= w_div0;
                        if (w_div0) begin
                            // Preloaded so FIX emits hi=a, lo=all ones unchanged
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_wh    <= a;
                            r_wl    <= '1;
                            r_m     <= '0;
                        end else if (op[1]) begin
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_wh    <= '0;
                            r_wl    <= w_a_mag;
                            r_m     <= w_b_mag;
                        end else begin
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= 1'b0;
                            r_wh    <= '0;
                            r_wl    <= w_b_mag;
                            r_m     <= w_a_mag;
                        end
                    end else begin
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                c_CALC: begin
                    r_wh  <= w_sh;
                    r_wl  <= w_sl;
                    r_cnt <= r_cnt - 1'b1;
                end
                c_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
